// File: rtl/simon_datapath.sv
// ---------------------------------------------------------------------------
// simon_datapath
//
// Datapath partner of the Simon game controller FSM. It holds every counter
// the controller steers: the pacing timer, the user timer, the score, the
// step counter and the LFSR that produces the light sequence. It also
// synchronises the player switches and drives the LEDs.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   timerCntEn, timerRst     pacing timer increment / clear
//   uTimerCntEn, uTimerRst   user timer increment / clear
//   scoreCntEn, scoreCntRst  score increment / clear
//   seqCntEn, seqCntRst      step counter increment / clear
//   rndSeqEn, rndSeqRst      LFSR advance / reload
//   lightAllSl, lightRndSl   LED selects (all lights, current sequence light)
//   simonsTurn               0 while the player enters switches (echoed to LEDs)
//   fini                     game over from the controller
//   sw[3:0]                  raw player switches
//   timerGtN, timerOut       pacing timer status
//   uTimerOut                user timer expired
//   seqEqScore               step counter has caught up with the score
//   anySwitch, switchMatch   synchronised switch status
//   led[3:0]                 registered light outputs
//   score                    current score
//   gameOver                 registered copy of fini
// ---------------------------------------------------------------------------
module simon_datapath #(
  parameter int          TIMER_W    = 8,
  parameter int          TIMER_MAX  = 200,
  parameter int          TIMER_N    = 100,
  parameter int          UTIMER_W   = 10,
  parameter int          UTIMER_MAX = 800,
  parameter int          SCORE_W    = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timerCntEn,
  input  logic               timerRst,
  input  logic               uTimerCntEn,
  input  logic               uTimerRst,
  input  logic               scoreCntEn,
  input  logic               scoreCntRst,
  input  logic               seqCntEn,
  input  logic               seqCntRst,
  input  logic               rndSeqEn,
  input  logic               rndSeqRst,
  input  logic               lightAllSl,
  input  logic               lightRndSl,
  input  logic               simonsTurn,
  input  logic               fini,
  input  logic [3:0]         sw,
  output logic               timerGtN,
  output logic               timerOut,
  output logic               uTimerOut,
  output logic               seqEqScore,
  output logic               anySwitch,
  output logic               switchMatch,
  output logic [3:0]         led,
  output logic [SCORE_W-1:0] score,
  output logic               gameOver
);

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [15:0]         SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [TIMER_W-1:0]  TMAX      = TIMER_W'(TIMER_MAX);
  localparam logic [TIMER_W-1:0]  TN        = TIMER_W'(TIMER_N);
  localparam logic [UTIMER_W-1:0] UMAX      = UTIMER_W'(UTIMER_MAX);
  localparam logic [SCORE_W-1:0]  SCORE_TOP = {SCORE_W{1'b1}};

  logic [TIMER_W-1:0]  timer;
  logic [UTIMER_W-1:0] uTimer;
  logic [SCORE_W-1:0]  scoreReg;
  logic [SCORE_W-1:0]  stepReg;
  logic [15:0]         lfsr;
  logic [3:0]          swMeta;
  logic [3:0]          swSync;
  logic [3:0]          idxHot;

  // One Fibonacci step: shift left, taps 15/13/12/10 feed bit 0.
  function automatic logic [15:0] lfsrStep(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // The current sequence light as a one-hot LED pattern.
  assign idxHot = 4'b0001 << lfsr[1:0];

  // Pacing timer wraps from its terminal count back to zero.
  always_ff @(posedge clk) begin
    if (rst || timerRst) begin
      timer <= '0;
    end else if (timerCntEn) begin
      timer <= (timer == TMAX) ? '0 : timer + TIMER_W'(1);
    end
  end

  // User timer sticks at its terminal count so the expiry flag holds.
  always_ff @(posedge clk) begin
    if (rst || uTimerRst) begin
      uTimer <= '0;
    end else if (uTimerCntEn && (uTimer != UMAX)) begin
      uTimer <= uTimer + UTIMER_W'(1);
    end
  end

  // Score and step counters saturate rather than wrap, so a long game
  // never makes seqEqScore fire falsely.
  always_ff @(posedge clk) begin
    if (rst || scoreCntRst) begin
      scoreReg <= '0;
    end else if (scoreCntEn && (scoreReg != SCORE_TOP)) begin
      scoreReg <= scoreReg + SCORE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || seqCntRst) begin
      stepReg <= '0;
    end else if (seqCntEn && (stepReg != SCORE_TOP)) begin
      stepReg <= stepReg + SCORE_W'(1);
    end
  end

  // Reload together with advance lands directly on the first sequence
  // element, so the controller's rewind-and-fetch pair can be repeated
  // without drifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED_EFF;
    end else if (rndSeqRst && rndSeqEn) begin
      lfsr <= lfsrStep(SEED_EFF);
    end else if (rndSeqRst) begin
      lfsr <= SEED_EFF;
    end else if (rndSeqEn) begin
      lfsr <= lfsrStep(lfsr);
    end
  end

  // Two-flop synchroniser for the asynchronous board switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      swMeta <= '0;
      swSync <= '0;
    end else begin
      swMeta <= sw;
      swSync <= swMeta;
    end
  end

  // LED drive with game over taking priority over every select, then the
  // all-lights flash, the sequence light, and finally the switch echo.
  always_ff @(posedge clk) begin
    if (rst) begin
      led      <= '0;
      gameOver <= 1'b0;
    end else begin
      gameOver <= fini;
      if (fini) begin
        led <= 4'h0;
      end else if (lightAllSl) begin
        led <= 4'hF;
      end else if (lightRndSl) begin
        led <= idxHot;
      end else if (!simonsTurn) begin
        led <= swSync;
      end else begin
        led <= 4'h0;
      end
    end
  end

  assign timerOut    = (timer == TMAX);
  assign timerGtN    = (timer > TN);
  assign uTimerOut   = (uTimer == UMAX);
  assign seqEqScore  = (stepReg == scoreReg);
  assign score       = scoreReg;
  assign anySwitch   = |swSync;
  assign switchMatch = (swSync == idxHot);

endmodule

// File: tb/tb_simon_datapath.sv
// ---------------------------------------------------------------------------
// tb_simon_datapath
//
// Directed bench for simon_datapath. A reference model holds the counters
// as plain integers and rebuilds the outputs from the game rules; a compare
// process checks every output against it on each falling edge. A handful of
// hand-worked values pin the model.
// ---------------------------------------------------------------------------
module tb_simon_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       timerCntEn, timerRst, uTimerCntEn, uTimerRst;
  logic       scoreCntEn, scoreCntRst, seqCntEn, seqCntRst;
  logic       rndSeqEn, rndSeqRst, lightAllSl, lightRndSl;
  logic       simonsTurn, fini;
  logic [3:0] sw;
  logic       timerGtN, timerOut, uTimerOut, seqEqScore, anySwitch, switchMatch;
  logic [3:0] led;
  logic [3:0] score;
  logic       gameOver;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 0;

  // Model state: counters as integers, LFSR as a 16-bit value.
  int          mTimer = 0, mUTimer = 0, mScore = 0, mStep = 0;
  logic [15:0] mLfsr  = 16'hACE1;
  logic [3:0]  mSw1 = 0, mSw2 = 0, mLed = 0;
  logic        mGameOver = 0;

  logic [3:0] runA [4];
  logic [3:0] runB [4];

  simon_datapath dut (
    .clk(clk), .rst(rst),
    .timerCntEn(timerCntEn), .timerRst(timerRst),
    .uTimerCntEn(uTimerCntEn), .uTimerRst(uTimerRst),
    .scoreCntEn(scoreCntEn), .scoreCntRst(scoreCntRst),
    .seqCntEn(seqCntEn), .seqCntRst(seqCntRst),
    .rndSeqEn(rndSeqEn), .rndSeqRst(rndSeqRst),
    .lightAllSl(lightAllSl), .lightRndSl(lightRndSl),
    .simonsTurn(simonsTurn), .fini(fini), .sw(sw),
    .timerGtN(timerGtN), .timerOut(timerOut), .uTimerOut(uTimerOut),
    .seqEqScore(seqEqScore), .anySwitch(anySwitch), .switchMatch(switchMatch),
    .led(led), .score(score), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nextRandom(input logic [15:0] q);
    logic fb;
    fb = q[15] ^ q[13] ^ q[12] ^ q[10];
    return {q[14:0], fb};
  endfunction

  function automatic logic [3:0] lightOf(input logic [15:0] q);
    logic [3:0] hot;
    hot = 4'b0000;
    hot[q[1:0]] = 1'b1;
    return hot;
  endfunction

  // Reference model: next state from the current inputs, evaluated at the
  // rising edge from the pre-edge model values.
  always @(posedge clk) begin
    logic [3:0] newLed;
    if (rst) begin
      mTimer = 0; mUTimer = 0; mScore = 0; mStep = 0;
      mLfsr = 16'hACE1; mSw1 = 0; mSw2 = 0; mLed = 0; mGameOver = 0;
    end else begin
      if (fini)             newLed = 4'h0;
      else if (lightAllSl)  newLed = 4'hF;
      else if (lightRndSl)  newLed = lightOf(mLfsr);
      else if (!simonsTurn) newLed = mSw2;
      else                  newLed = 4'h0;

      if (timerRst)        mTimer = 0;
      else if (timerCntEn) mTimer = (mTimer + 1) % 201;

      if (uTimerRst)        mUTimer = 0;
      else if (uTimerCntEn) mUTimer = (mUTimer >= 800) ? 800 : mUTimer + 1;

      if (scoreCntRst)     mScore = 0;
      else if (scoreCntEn) mScore = (mScore >= 15) ? 15 : mScore + 1;

      if (seqCntRst)     mStep = 0;
      else if (seqCntEn) mStep = (mStep >= 15) ? 15 : mStep + 1;

      if (rndSeqRst && rndSeqEn) mLfsr = nextRandom(16'hACE1);
      else if (rndSeqRst)        mLfsr = 16'hACE1;
      else if (rndSeqEn)         mLfsr = nextRandom(mLfsr);

      mSw2 = mSw1;
      mSw1 = sw;
      mGameOver = fini;
      mLed = newLed;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("timerGtN",    16'(timerGtN),    16'(mTimer > 100));
      checkOutput("timerOut",    16'(timerOut),    16'(mTimer == 200));
      checkOutput("uTimerOut",   16'(uTimerOut),   16'(mUTimer == 800));
      checkOutput("seqEqScore",  16'(seqEqScore),  16'(mStep == mScore));
      checkOutput("anySwitch",   16'(anySwitch),   16'(mSw2 != 4'h0));
      checkOutput("switchMatch", 16'(switchMatch), 16'(mSw2 == lightOf(mLfsr)));
      checkOutput("led",         16'(led),         16'(mLed));
      checkOutput("score",       16'(score),       16'(mScore));
      checkOutput("gameOver",    16'(gameOver),    16'(mGameOver));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1; timerCntEn = 0; timerRst = 0; uTimerCntEn = 0; uTimerRst = 0;
    scoreCntEn = 0; scoreCntRst = 0; seqCntEn = 0; seqCntRst = 0;
    rndSeqEn = 0; rndSeqRst = 0; lightAllSl = 0; lightRndSl = 0;
    simonsTurn = 1; fini = 0; sw = 4'h0;
    applyStimulus(3);
    rst = 0;
    checkEn = 1;
    checkOutput("rst seqEqScore", 16'(seqEqScore), 16'd1);
    checkOutput("rst timerOut",   16'(timerOut),   16'd0);
    checkOutput("rst led",        16'(led),        16'd0);
    checkOutput("rst score",      16'(score),      16'd0);

    // Pacing timer through its full period and wrap.
    $display("[TB] pacing timer");
    timerCntEn = 1;
    for (int k = 1; k <= 201; k++) begin
      applyStimulus(1);
      if (k == 100) checkOutput("timerGtN@100", 16'(timerGtN), 16'd0);
      if (k == 101) checkOutput("timerGtN@101", 16'(timerGtN), 16'd1);
      if (k == 199) checkOutput("timerOut@199", 16'(timerOut), 16'd0);
      if (k == 200) checkOutput("timerOut@200", 16'(timerOut), 16'd1);
      if (k == 201) checkOutput("timer wrap",   16'(timerGtN | timerOut), 16'd0);
    end
    for (int k = 0; k < 150; k++) applyStimulus(1);
    timerRst = 1;
    applyStimulus(1);
    checkOutput("timerRst wins", 16'(timerGtN), 16'd0);
    timerCntEn = 0; timerRst = 0;

    // User timer saturation and clear.
    $display("[TB] user timer");
    uTimerCntEn = 1;
    for (int k = 1; k <= 900; k++) begin
      applyStimulus(1);
      if (k == 799) checkOutput("uTimerOut@799", 16'(uTimerOut), 16'd0);
      if (k == 800) checkOutput("uTimerOut@800", 16'(uTimerOut), 16'd1);
      if (k == 900) checkOutput("uTimerOut@900", 16'(uTimerOut), 16'd1);
    end
    uTimerCntEn = 0; uTimerRst = 1;
    applyStimulus(1);
    checkOutput("uTimerRst", 16'(uTimerOut), 16'd0);
    uTimerRst = 0;

    // Sequence rewind and replay; the LEDs show the light one cycle late.
    $display("[TB] random sequence");
    lightRndSl = 1;
    for (int r = 0; r < 2; r++) begin
      rndSeqRst = 1; rndSeqEn = 1;
      applyStimulus(1);
      rndSeqRst = 0;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) rndSeqEn = 0;
        applyStimulus(1);
        if (r == 0) runA[k] = led; else runB[k] = led;
      end
    end
    for (int k = 0; k < 4; k++) checkOutput("replay", 16'(runB[k]), 16'(runA[k]));
    checkOutput("first light",  16'(runA[0]), 16'b1000);
    checkOutput("fourth light", 16'(runA[3]), 16'b0100);

    // LED priority with the current light index at 2.
    $display("[TB] led priority");
    applyStimulus(1);
    checkOutput("led rnd",  16'(led), 16'b0100);
    lightAllSl = 1;
    applyStimulus(1);
    checkOutput("led all",  16'(led), 16'hF);
    fini = 1;
    applyStimulus(1);
    checkOutput("led fini", 16'(led), 16'h0);
    checkOutput("gameOver", 16'(gameOver), 16'd1);
    fini = 0; lightAllSl = 0; lightRndSl = 0;

    // Switch synchroniser and matching against light index 2.
    $display("[TB] switches");
    simonsTurn = 0; sw = 4'b0100;
    applyStimulus(1);
    checkOutput("sw latency", 16'(anySwitch), 16'd0);
    applyStimulus(1);
    checkOutput("anySwitch",   16'(anySwitch),   16'd1);
    checkOutput("switchMatch", 16'(switchMatch), 16'd1);
    applyStimulus(1);
    checkOutput("led echo", 16'(led), 16'b0100);
    sw = 4'b0110;
    applyStimulus(2);
    checkOutput("multi anySwitch",   16'(anySwitch),   16'd1);
    checkOutput("multi switchMatch", 16'(switchMatch), 16'd0);
    sw = 4'b0001;
    applyStimulus(2);
    checkOutput("wrong switchMatch", 16'(switchMatch), 16'd0);
    sw = 4'h0; simonsTurn = 1;
    applyStimulus(3);

    // Score versus step counter, then score saturation.
    $display("[TB] score");
    scoreCntEn = 1; applyStimulus(3); scoreCntEn = 0;
    seqCntEn = 1;   applyStimulus(3); seqCntEn = 0;
    applyStimulus(1);
    checkOutput("score 3",     16'(score),      16'd3);
    checkOutput("seqEqScore",  16'(seqEqScore), 16'd1);
    seqCntEn = 1; applyStimulus(1); seqCntEn = 0;
    applyStimulus(1);
    checkOutput("seqEqScore off", 16'(seqEqScore), 16'd0);
    scoreCntEn = 1; applyStimulus(20); scoreCntEn = 0;
    applyStimulus(1);
    checkOutput("score sat", 16'(score), 16'd15);
    scoreCntEn = 1; scoreCntRst = 1; seqCntEn = 1; seqCntRst = 1;
    applyStimulus(1);
    scoreCntEn = 0; scoreCntRst = 0; seqCntEn = 0; seqCntRst = 0;
    checkOutput("score rst wins", 16'(score), 16'd0);
    checkOutput("both cleared",   16'(seqEqScore), 16'd1);
    applyStimulus(2);

    checkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
